// File: rtl/m_pcpi_arbiter.sv
// m_pcpi_arbiter: shares one PCPI M-extension unit between two PCPI requesters.
// It decodes requests, arbitrates in IDLE, holds the instruction and operands
// stable for the whole operation, and routes the result back to the winner.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   reqN_valid/insn/rs1/rs2       requester N PCPI request (N = 0, 1)
//   reqN_ready/wr/rd              result pulse, write-back enable, result
//   reqN_busy                     request accepted or pending
//   m_valid, m_insn, m_rs1, m_rs2 issue to the shared unit
//   m_ready, m_wr, m_rd, m_busy   unit response
//
// Build option M_ARB_RR_EN: when defined, simultaneous requests are resolved
// round-robin with a one-bit last-grant pointer. When undefined, req0 has fixed
// priority and a starvation counter forces req1 after STARVE_LIMIT req0 grants.
module m_pcpi_arbiter
`ifndef M_ARB_RR_EN
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_insn,
  input  logic [31:0] req0_rs1,
  input  logic [31:0] req0_rs2,
  output logic        req0_ready,
  output logic        req0_wr,
  output logic [31:0] req0_rd,
  output logic        req0_busy,
  input  logic        req1_valid,
  input  logic [31:0] req1_insn,
  input  logic [31:0] req1_rs1,
  input  logic [31:0] req1_rs2,
  output logic        req1_ready,
  output logic        req1_wr,
  output logic [31:0] req1_rd,
  output logic        req1_busy,
  output logic        m_valid,
  output logic [31:0] m_insn,
  output logic [31:0] m_rs1,
  output logic [31:0] m_rs2,
  input  logic        m_ready,
  input  logic        m_wr,
  input  logic [31:0] m_rd,
  input  logic        m_busy
);

  localparam int unsigned XLEN = 32;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              grant_q;      // 0: req0 owns the unit, 1: req1
  logic [XLEN-1:0]   rd_q;
  logic              wr_q;
  logic              pend0;
  logic              pend1;
  logic              prefer1;
  logic              take;
  logic              pick;
  logic              resp0;
  logic              resp1;

  // Unit busy is informational only; the unit's ready alone ends ISSUE.
  logic unused_m_busy;
  assign unused_m_busy = m_busy;

  // Only M-extension (MUL/DIV family) encodings are ever arbitrated.
  function automatic logic is_muldiv(input logic [XLEN-1:0] insn);
    return (insn[6:0] == OPC_OP) && (insn[31:25] == F7_MULDIV);
  endfunction

  assign pend0 = req0_valid && is_muldiv(req0_insn);
  assign pend1 = req1_valid && is_muldiv(req1_insn);

`ifdef M_ARB_RR_EN
  // Last-grant pointer; resets to "req1 last" so req0 wins the first tie.
  logic last_q;
  assign prefer1 = ~last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (take) begin
      last_q <= pick;
    end
  end
`else
  // Counts req0 grants made while req1 waits; at the limit req1 wins a tie.
  logic [CNT_W-1:0] starve_q;
  assign prefer1 = (starve_q == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else if (!pend1) begin
      starve_q <= '0;
    end else if (take && pick) begin
      starve_q <= '0;
    end else if (take && !pick && !prefer1) begin
      starve_q <= starve_q + CNT_W'(1);
    end
  end
`endif

  // Next-state and grant decision.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    pick      = 1'b0;
    case (state)
      IDLE: begin
        if (pend0 || pend1) begin
          take      = 1'b1;
          pick      = (pend0 && pend1) ? prefer1 : pend1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (m_ready) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, captured request and captured unit response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant_q <= 1'b0;
      m_insn  <= '0;
      m_rs1   <= '0;
      m_rs2   <= '0;
      rd_q    <= '0;
      wr_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        grant_q <= pick;
        m_insn  <= pick ? req1_insn : req0_insn;
        m_rs1   <= pick ? req1_rs1  : req0_rs1;
        m_rs2   <= pick ? req1_rs2  : req0_rs2;
      end
      if ((state == ISSUE) && m_ready) begin
        rd_q <= m_rd;
        wr_q <= m_wr;
      end
    end
  end

  // Unit handshake: valid only in ISSUE, so it is low the cycle after ready.
  assign m_valid = (state == ISSUE);

  assign resp0 = (state == RESP) && !grant_q;
  assign resp1 = (state == RESP) &&  grant_q;

  // A requester that dropped valid during the operation gets no pulse.
  assign req0_ready = resp0 && req0_valid;
  assign req1_ready = resp1 && req1_valid;
  assign req0_wr    = req0_ready && wr_q;
  assign req1_wr    = req1_ready && wr_q;
  assign req0_rd    = resp0 ? rd_q : '0;
  assign req1_rd    = resp1 ? rd_q : '0;

  // Busy covers both the granted and the waiting requester.
  assign req0_busy = !reset && pend0 && !resp0;
  assign req1_busy = !reset && pend1 && !resp1;

endmodule

// File: tb/tb_m_pcpi_arbiter.sv
// tb_m_pcpi_arbiter: randomized and directed bench for m_pcpi_arbiter.
// A behavioural M unit answers the arbiter; a queue-level arbitration model
// predicts the grant order and an arithmetic model predicts every result.
module tb_m_pcpi_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int FULL_DIV_LAT = 34;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  typedef struct packed {
    logic        id;
    logic [31:0] rd;
    logic        wr;
    op_t         op;
  } resp_t;

  typedef struct packed {
    logic id;
    op_t  op;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rv [2];
  logic [31:0] ri [2];
  logic [31:0] ra [2];
  logic [31:0] rb [2];

  logic        req0_ready, req0_wr, req0_busy;
  logic        req1_ready, req1_wr, req1_busy;
  logic [31:0] req0_rd, req1_rd;
  logic        m_valid;
  logic [31:0] m_insn, m_rs1, m_rs2;
  logic        m_ready, m_wr, m_busy;
  logic [31:0] m_rd;

  logic [1:0]  rdy_v, wr_v, busy_v;
  logic [31:0] rdo [2];

  int n_chk = 0;
  int n_pass = 0;

  op_t   q0[$];
  op_t   q1[$];
  resp_t got[$];
  exp_t  exp_q[$];
  int    obs_viol;
  int    mv_cyc;
  int    m_starve;
  logic  m_last;
  int    ucnt;

  always #5 clk = ~clk;

  m_pcpi_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (rv[0]),
    .req0_insn  (ri[0]),
    .req0_rs1   (ra[0]),
    .req0_rs2   (rb[0]),
    .req0_ready (req0_ready),
    .req0_wr    (req0_wr),
    .req0_rd    (req0_rd),
    .req0_busy  (req0_busy),
    .req1_valid (rv[1]),
    .req1_insn  (ri[1]),
    .req1_rs1   (ra[1]),
    .req1_rs2   (rb[1]),
    .req1_ready (req1_ready),
    .req1_wr    (req1_wr),
    .req1_rd    (req1_rd),
    .req1_busy  (req1_busy),
    .m_valid    (m_valid),
    .m_insn     (m_insn),
    .m_rs1      (m_rs1),
    .m_rs2      (m_rs2),
    .m_ready    (m_ready),
    .m_wr       (m_wr),
    .m_rd       (m_rd),
    .m_busy     (m_busy)
  );

  assign rdy_v  = {req1_ready, req0_ready};
  assign wr_v   = {req1_wr, req0_wr};
  assign busy_v = {req1_busy, req0_busy};
  assign rdo[0] = req0_rd;
  assign rdo[1] = req1_rd;

  // RISC-V M-extension result from the instruction's funct3.
  function automatic logic [31:0] m_ref(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (insn[14:12])
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * longint'({32'd0, b})); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int unit_lat(input logic [31:0] insn, input logic [31:0] b);
    if (insn[14] && b != 32'd0) return FULL_DIV_LAT;
    return 1;
  endfunction

  function automatic logic is_mdu(input logic [31:0] insn);
    return insn[6:0] == 7'b0110011 && insn[31:25] == 7'b0000001;
  endfunction

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rdf);
    return {7'b0000001, 5'd2, 5'd1, f3, rdf, 7'b0110011};
  endfunction

  function automatic op_t mk_op(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
    op_t o;
    o.insn = insn; o.a = a; o.b = b;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.insn = mk(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
    o.a = $urandom;
    o.b = $urandom;
    case ($urandom_range(0, 7))
      0: o.b = 32'd0;
      1: begin o.a = 32'h8000_0000; o.b = 32'hFFFF_FFFF; end
      default: ;
    endcase
    return o;
  endfunction

  // Behavioural M unit: answers m_valid after the instruction's latency.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ready <= 1'b0; m_wr <= 1'b0; m_rd <= '0; ucnt <= 0;
    end else if (m_ready) begin
      m_ready <= 1'b0; m_wr <= 1'b0; m_rd <= '0; ucnt <= 0;
    end else if (m_valid) begin
      if (ucnt + 1 >= unit_lat(m_insn, m_rs2)) begin
        m_ready <= 1'b1;
        m_wr    <= (m_insn[11:7] != 5'd0);
        m_rd    <= m_ref(m_insn, m_rs1, m_rs2);
      end else begin
        ucnt <= ucnt + 1;
      end
    end
  end
  assign m_busy = m_valid | m_ready;

  task automatic drive(input int i, input op_t o);
    rv[i] = 1'b1; ri[i] = o.insn; ra[i] = o.a; rb[i] = o.b;
  endtask

  // Grant order from the arbitration rules, applied to whole queues.
  task automatic predict();
    op_t a[$];
    op_t b[$];
    exp_t e;
    logic pk;
    a = q0; b = q1;
    exp_q.delete();
    while (a.size() > 0 || b.size() > 0) begin
      if (a.size() > 0 && b.size() > 0) begin
`ifdef M_ARB_RR_EN
        pk = !m_last;
`else
        pk = (m_starve == STARVE_LIMIT);
`endif
      end else begin
        pk = (b.size() > 0);
      end
      e.id = pk;
      if (pk) begin
        e.op = b.pop_front();
        m_starve = 0;
      end else begin
        e.op = a.pop_front();
        m_starve = (b.size() > 0) ? m_starve + 1 : 0;
      end
      m_last = pk;
      exp_q.push_back(e);
    end
    m_starve = 0;
  endtask

  // Requester driver: feeds q0/q1 back to back and logs every ready pulse.
  task automatic serve(input int max_cyc, output int used);
    op_t   cur [2];
    resp_t r;
    used = 0; mv_cyc = 0; obs_viol = 0;
    got.delete();
    if (q0.size() > 0) begin cur[0] = q0.pop_front(); drive(0, cur[0]); end
    if (q1.size() > 0) begin cur[1] = q1.pop_front(); drive(1, cur[1]); end
    while ((rv[0] || rv[1]) && used < max_cyc) begin
      @(negedge clk);
      used++;
      if (m_valid) mv_cyc++;
      for (int i = 0; i < 2; i++) begin
        if (rv[i] && is_mdu(ri[i])) begin
          if (busy_v[i] == rdy_v[i]) obs_viol++;
          if (!rdy_v[i] && (wr_v[i] || rdo[i] != 32'd0)) obs_viol++;
          if (rdy_v[i]) begin
            r.id = 1'(i); r.rd = rdo[i]; r.wr = wr_v[i]; r.op = cur[i];
            got.push_back(r);
            if (i == 0 && q0.size() > 0) begin cur[0] = q0.pop_front(); drive(0, cur[0]); end
            else if (i == 1 && q1.size() > 0) begin cur[1] = q1.pop_front(); drive(1, cur[1]); end
            else rv[i] = 1'b0;
          end
        end else if (busy_v[i] || rdy_v[i] || wr_v[i]) begin
          obs_viol++;
        end
      end
    end
    rv[0] = 1'b0; rv[1] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rv[0] = 1'b0; rv[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin ri[i] = '0; ra[i] = '0; rb[i] = '0; end
    m_starve = 0; m_last = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({m_valid, req0_ready, req0_wr, req0_busy, req1_ready, req1_wr, req1_busy,
         m_insn, m_rs1, m_rs2, req0_rd, req1_rd} !== '0)
      $display("FAIL reset_outputs: m_valid=%b m_insn=%h req0_rd=%h req1_rd=%h required all zero",
               m_valid, m_insn, req0_rd, req1_rd);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul_basic();
    int used;
    q0.push_back(mk_op(32'h02B5_0533, 32'd7, 32'd6));
    predict();
    serve(50, used);
    n_chk++;
    if (got.size() != 1) $display("FAIL mul_count: got %0d responses, required 1", got.size());
    else n_pass++;
    if (got.size() == 1) begin
      n_chk++;
      if (got[0].id !== 1'b0 || got[0].rd !== 32'd42 || got[0].wr !== 1'b1)
        $display("FAIL mul_result: id=%0d rd=%h wr=%b, required id=0 rd=0000002a wr=1",
                 got[0].id, got[0].rd, got[0].wr);
      else n_pass++;
    end
    n_chk++;
    if (used != 3) $display("FAIL mul_latency: ready after %0d cycles, required 3", used);
    else n_pass++;
    n_chk++;
    if (mv_cyc != 2) $display("FAIL mul_m_valid_window: m_valid high %0d cycles, required 2", mv_cyc);
    else n_pass++;
    n_chk++;
    if (obs_viol != 0) $display("FAIL mul_side_outputs: %0d bad busy/ready/rd samples, required 0", obs_viol);
    else n_pass++;
  endtask

  task automatic test_div_by_zero();
    int used;
    q1.push_back(mk_op(mk(3'd5, 5'd3), 32'd100, 32'd0));
    q1.push_back(mk_op(mk(3'd7, 5'd3), 32'd100, 32'd0));
    predict();
    serve(100, used);
    n_chk++;
    if (got.size() != 2) $display("FAIL divz_count: got %0d responses, required 2", got.size());
    else n_pass++;
    if (got.size() == 2) begin
      n_chk++;
      if (got[0].id !== 1'b1 || got[0].rd !== 32'hFFFF_FFFF)
        $display("FAIL divu_zero: id=%0d rd=%h, required id=1 rd=ffffffff", got[0].id, got[0].rd);
      else n_pass++;
      n_chk++;
      if (got[1].id !== 1'b1 || got[1].rd !== 32'd100)
        $display("FAIL remu_zero: id=%0d rd=%h, required id=1 rd=00000064", got[1].id, got[1].rd);
      else n_pass++;
    end
    n_chk++;
    if (obs_viol != 0) $display("FAIL divz_side_outputs: %0d bad samples, required 0", obs_viol);
    else n_pass++;
  endtask

  // Two simultaneous pairs; order comes from the arbitration model.
  task automatic test_simultaneous();
    int used;
    for (int pass = 0; pass < 2; pass++) begin
      q0.push_back(mk_op(mk(3'd1, 5'd4), 32'hFFFF_FFFE, 32'd3));
      q1.push_back(mk_op(mk(3'd4, 5'd5), 32'hFFFF_FFEC, 32'd3));
      predict();
      serve(100, used);
      n_chk++;
      if (got.size() != 2) $display("FAIL simul_count: pass %0d got %0d, required 2", pass, got.size());
      else n_pass++;
      for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
        n_chk++;
        if (got[k].id !== exp_q[k].id)
          $display("FAIL simul_order: pass %0d slot %0d id=%0d, required %0d", pass, k, got[k].id, exp_q[k].id);
        else n_pass++;
        n_chk++;
        if (got[k].rd !== (got[k].id ? 32'hFFFF_FFFA : 32'hFFFF_FFFF))
          $display("FAIL simul_rd: pass %0d req%0d rd=%h, required %h", pass, got[k].id, got[k].rd,
                   got[k].id ? 32'hFFFF_FFFA : 32'hFFFF_FFFF);
        else n_pass++;
      end
      if (pass == 0 && got.size() > 0) begin
        n_chk++;
        if (got[0].id !== 1'b0) $display("FAIL simul_first: first grant req%0d, required req0", got[0].id);
        else n_pass++;
      end
    end
  endtask

  task automatic test_starvation();
    int used;
    int pos1;
    for (int k = 0; k < 5; k++) q0.push_back(mk_op(mk(3'd0, 5'd1), $urandom, $urandom));
    q1.push_back(mk_op(mk(3'd0, 5'd2), 32'd9, 32'd9));
    predict();
    serve(200, used);
    n_chk++;
    if (got.size() != 6) $display("FAIL starve_count: got %0d responses, required 6", got.size());
    else n_pass++;
    pos1 = -1;
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      if (got[k].id) pos1 = k;
      n_chk++;
      if (got[k].id !== exp_q[k].id || got[k].rd !== m_ref(got[k].op.insn, got[k].op.a, got[k].op.b))
        $display("FAIL starve_order: slot %0d id=%0d rd=%h, required id=%0d rd=%h", k, got[k].id,
                 got[k].rd, exp_q[k].id, m_ref(exp_q[k].op.insn, exp_q[k].op.a, exp_q[k].op.b));
      else n_pass++;
    end
`ifndef M_ARB_RR_EN
    n_chk++;
    if (pos1 != STARVE_LIMIT) $display("FAIL starve_force: req1 served in slot %0d, required %0d", pos1, STARVE_LIMIT);
    else n_pass++;
`endif
    n_chk++;
    if (obs_viol != 0) $display("FAIL starve_busy: %0d bad busy/ready samples, required 0", obs_viol);
    else n_pass++;
  endtask

  task automatic test_nonmatch();
    int mv, bz, rdy;
    mv = 0; bz = 0; rdy = 0;
    drive(0, mk_op({7'b0000000, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011}, 32'd1, 32'd2));
    repeat (20) begin
      @(negedge clk);
      if (m_valid) mv++;
      if (req0_busy) bz++;
      if (req0_ready || req0_wr || req0_rd != 32'd0) rdy++;
    end
    rv[0] = 1'b0;
    n_chk++;
    if (mv != 0) $display("FAIL nonmatch_m_valid: high %0d cycles, required 0", mv);
    else n_pass++;
    n_chk++;
    if (bz != 0) $display("FAIL nonmatch_busy: high %0d cycles, required 0", bz);
    else n_pass++;
    n_chk++;
    if (rdy != 0) $display("FAIL nonmatch_ready: %0d response samples, required 0", rdy);
    else n_pass++;
  endtask

  // Requester withdraws mid-divide: no pulse, then the arbiter is free again.
  task automatic test_drop_valid();
    int rdy, w, used;
    rdy = 0; w = 0;
    drive(0, mk_op(mk(3'd5, 5'd3), 32'd1000, 32'd7));
    while (!m_valid && w < 10) begin @(negedge clk); w++; end
    repeat (5) @(negedge clk);
    rv[0] = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (req0_ready || req0_wr || req1_ready) rdy++;
    end
    m_last = 1'b0;
    n_chk++;
    if (rdy != 0 || m_valid !== 1'b0) $display("FAIL drop_valid: %0d pulses m_valid=%b, required 0 and 0", rdy, m_valid);
    else n_pass++;
    q1.push_back(mk_op(mk(3'd0, 5'd6), 32'd12, 32'd12));
    predict();
    serve(50, used);
    n_chk++;
    if (got.size() != 1 || got[0].rd !== 32'd144)
      $display("FAIL drop_recover: %0d responses rd=%h, required 1 with rd=00000090", got.size(),
               got.size() > 0 ? got[0].rd : 32'd0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    int w, used;
    w = 0;
    drive(0, mk_op(mk(3'd5, 5'd3), 32'd1000, 32'd7));
    while (!m_valid && w < 10) begin @(negedge clk); w++; end
    repeat (10) @(negedge clk);
    n_chk++;
    if (m_valid !== 1'b1) $display("FAIL midreset_setup: m_valid=%b, required 1", m_valid);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_chk++;
    if ({m_valid, req0_ready, req0_wr, req0_busy, req1_ready, req1_wr, req1_busy,
         m_insn, m_rs1, m_rs2, req0_rd, req1_rd} !== '0)
      $display("FAIL midreset_outputs: m_valid=%b req0_busy=%b m_insn=%h m_rs1=%h, required all zero",
               m_valid, req0_busy, m_insn, m_rs1);
    else n_pass++;
    rv[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_starve = 0; m_last = 1'b1;
    @(negedge clk);
    q0.push_back(mk_op(mk(3'd3, 5'd3), 32'hFFFF_FFFF, 32'd2));
    predict();
    serve(50, used);
    n_chk++;
    if (got.size() != 1 || got[0].rd !== 32'd1)
      $display("FAIL midreset_mulhu: %0d responses rd=%h, required 1 with rd=00000001", got.size(),
               got.size() > 0 ? got[0].rd : 32'd0);
    else n_pass++;
  endtask

  task automatic test_random();
    int used;
    for (int k = 0; k < 12; k++) begin
      q0.push_back(rand_op());
      q1.push_back(rand_op());
    end
    predict();
    serve(3000, used);
    n_chk++;
    if (got.size() != exp_q.size()) $display("FAIL rand_count: got %0d, required %0d", got.size(), exp_q.size());
    else n_pass++;
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      n_chk++;
      if (got[k].id !== exp_q[k].id || got[k].op !== exp_q[k].op)
        $display("FAIL rand_order: slot %0d req%0d insn=%h, required req%0d insn=%h", k, got[k].id,
                 got[k].op.insn, exp_q[k].id, exp_q[k].op.insn);
      else n_pass++;
      n_chk++;
      if (got[k].rd !== m_ref(exp_q[k].op.insn, exp_q[k].op.a, exp_q[k].op.b) ||
          got[k].wr !== (exp_q[k].op.insn[11:7] != 5'd0))
        $display("FAIL rand_result: slot %0d rd=%h wr=%b, required rd=%h wr=%b", k, got[k].rd, got[k].wr,
                 m_ref(exp_q[k].op.insn, exp_q[k].op.a, exp_q[k].op.b), exp_q[k].op.insn[11:7] != 5'd0);
      else n_pass++;
    end
    n_chk++;
    if (obs_viol != 0) $display("FAIL rand_side_outputs: %0d bad samples, required 0", obs_viol);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_div_by_zero();
    test_simultaneous();
    test_starvation();
    test_nonmatch();
    test_drop_valid();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/m_pcpi_arbiter.md
Name: m_pcpi_arbiter

Overview:
- Shares one M-extension coprocessor (PCPI slave: controller plus datapath) between two PCPI requesters, e.g. core and debug/self-test master.
- Decodes requests, arbitrates, captures and holds the instruction and operands for the whole operation, issues to the unit, and routes the result back.
- Sits between the requesters' PCPI ports and the single M unit in the SoC top.

Parameters:
- STARVE_LIMIT, 4, consecutive req0 grants allowed while req1 waits before req1 is forced (fixed-priority mode only).
- CNT_W, 3, width of the starvation counter; must satisfy 2**CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req0_valid / req1_valid  in  1  requester PCPI valid
- req0_insn / req1_insn  in  32  instruction word
- req0_rs1, req0_rs2 / req1_rs1, req1_rs2  in  32  operands
- req0_ready / req1_ready  out  1  result valid, one-cycle pulse
- req0_wr / req1_wr  out  1  write-back enable, same cycle as ready
- req0_rd / req1_rd  out  32  result
- req0_busy / req1_busy  out  1  request accepted or pending
- m_valid  out  1  to unit pcpi_valid
- m_insn, m_rs1, m_rs2  out  32  to unit, registered
- m_ready, m_wr  in  1  from unit
- m_rd  in  32  from unit result
- m_busy  in  1  from unit busy

Behaviour:
- Match rule: insn[6:0]==7'b0110011 and insn[31:25]==7'b0000001.
  - Non-matching requests are never granted and never get busy/ready.
- FSM states:
  - IDLE
    - Evaluate matching valid requests.
    - On grant: capture insn/rs1/rs2 into m_* registers, store grant id, go to ISSUE.
  - ISSUE
    - m_valid=1 (combinational from state).
    - On m_ready: capture m_rd and m_wr, go to RESP.
  - RESP
    - m_valid=0.
    - Granted reqX_ready=1 and reqX_wr=captured wr, both gated by reqX_valid still high.
    - reqX_rd=captured rd.
    - Always go to IDLE.
- m_valid must be low in the cycle after the unit's ready so the unit cannot re-trigger.
- m_insn/m_rs1/m_rs2 are stable from ISSUE entry until RESP exit. The unit re-reads rs1/rs2 in its final state.
- Latency: request seen in IDLE at cycle t → ISSUE at t+1 → unit ready at t+1+L → reqX_ready at t+2+L.
  - L=1 for MUL-class instructions with operands.
  - Early-exit divide: L=1.
  - Full divide: about L=34.
- reqX_busy:
  - =1 when reqX_valid and matching and not in the RESP cycle for X.
  - Covers both the granted and the pending requester, so the requester's timeout does not fire.
  - =0 otherwise.
- reqX_rd=0 except in its RESP cycle.
- Fixed priority (macro off):
  - req0 wins simultaneous requests.
  - Starvation counter increments on each req0 grant while req1 is pending-valid-matching, and clears on any req1 grant or when req1 is idle.
  - When counter==STARVE_LIMIT, req1 wins the next simultaneous arbitration.
- Requester drops valid during ISSUE:
  - The operation completes and the result is discarded (no ready pulse).
  - FSM still passes through RESP to IDLE.
- A new request arriving during ISSUE/RESP waits. Arbitration happens only in IDLE.
- Reset (any state, including mid-ISSUE):
  - State to IDLE; m_valid, m_* registers, all req outputs, grant id and counter to 0; RR pointer to "last=1".
  - The unit is reset by the same top-level reset (inverted to its resetn).
- Every output has reset value 0.

Optional Feature:
- M_ARB_RR_EN
  - Defined: round-robin. A one-bit last-grant pointer updates on each grant; on simultaneous requests the requester not last granted wins. STARVE_LIMIT and the counter are unused and removed.
  - Undefined: fixed priority with the starvation counter as specified.

Test Plan:
- req0 MUL (insn 0x02B50533), rs1=7, rs2=6 → m_valid one ISSUE window; req0_ready/wr pulse 1 cycle with rd=42; req1 outputs 0.
- req1 DIVU rs1=100, rs2=0 → rd=0xFFFFFFFF; req1 REMU same operands → rd=100.
- Both valid in the same IDLE cycle, req0 MULH(−2,3), req1 DIV(−20,3):
  - Fixed mode: req0 rd=0xFFFFFFFF first, then req1 rd=0xFFFFFFFA.
  - RR mode after reset: req0 first, and the next simultaneous pair goes to req1.
- req0 issues 5 back-to-back MULs with req1 continuously valid, STARVE_LIMIT=4 → req1 granted after the 4th req0 grant; req1_busy high throughout the wait.
- req0 valid with ADD (func7=0) → no grant, m_valid stays 0, req0_busy=0, no ready.
- Reset asserted mid full DIVU (ISSUE, 10 cycles in) → all outputs 0 immediately; after release a fresh MULHU 0xFFFFFFFF*2 returns rd=1.
